// File: rtl/sync_frame_tx.sv
// Bit-serial frame transmitter: sync pattern, payload MSB first, then an idle-low gap.
// Optional even-parity bit after the payload when SYNC_FRAME_TX_PARITY_EN is defined.
module sync_frame_tx #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011,
    parameter int unsigned       GAP_BITS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              out,
    output logic              out_valid,
    output logic              frame_done
);

    localparam int unsigned M1   = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int unsigned MAXV = (M1 > GAP_BITS) ? M1 : GAP_BITS;
    localparam int unsigned CW   = $clog2(MAXV + 1);
    localparam int unsigned FW   = SYNC_W + DATA_W;

    localparam logic [CW-1:0] SYNC_LD = CW'(SYNC_W - 1);
    localparam logic [CW-1:0] DATA_LD = CW'(DATA_W - 1);
    localparam logic [CW-1:0] GAP_LD  = (GAP_BITS > 0) ? CW'(GAP_BITS - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
`ifdef SYNC_FRAME_TX_PARITY_EN
        PARITY,
`endif
        GAP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [FW-1:0] sh, sh_n;
    logic          accept;
    logic          out_d, valid_d, done_d;
`ifdef SYNC_FRAME_TX_PARITY_EN
    logic          par;
`endif

    assign din_ready = (state == IDLE) && !reset;
    assign accept    = din_valid && din_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sh         <= '0;
            out        <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
`ifdef SYNC_FRAME_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sh         <= sh_n;
            out        <= out_d;
            out_valid  <= valid_d;
            frame_done <= done_d;
`ifdef SYNC_FRAME_TX_PARITY_EN
            if (accept)
                par <= ^din;
`endif
        end
    end

    // Sync and payload share one shift register; its MSB is always the next bit to send.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = SYNC;
                    cnt_n   = SYNC_LD;
                    sh_n    = {SYNC_PAT, din};
                end
            end
            SYNC: begin
                sh_n = sh << 1;
                if (cnt == '0) begin
                    state_n = DATA;
                    cnt_n   = DATA_LD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DATA: begin
                sh_n = sh << 1;
                if (cnt == '0) begin
`ifdef SYNC_FRAME_TX_PARITY_EN
                    state_n = PARITY;
                    cnt_n   = '0;
`else
                    if (GAP_BITS == 0) begin
                        state_n = IDLE;
                    end else begin
                        state_n = GAP;
                        cnt_n   = GAP_LD;
                    end
`endif
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
`ifdef SYNC_FRAME_TX_PARITY_EN
            PARITY: begin
                if (GAP_BITS == 0) begin
                    state_n = IDLE;
                end else begin
                    state_n = GAP;
                    cnt_n   = GAP_LD;
                end
            end
`endif
            GAP: begin
                if (cnt == '0)
                    state_n = IDLE;
                else
                    cnt_n = cnt - 1'b1;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with it.
    always_comb begin
        out_d   = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        case (state_n)
            SYNC: begin
                out_d   = sh_n[FW-1];
                valid_d = 1'b1;
            end
            DATA: begin
                out_d   = sh_n[FW-1];
                valid_d = 1'b1;
`ifndef SYNC_FRAME_TX_PARITY_EN
                done_d  = (cnt_n == '0);
`endif
            end
`ifdef SYNC_FRAME_TX_PARITY_EN
            PARITY: begin
                out_d   = par;
                valid_d = 1'b1;
                done_d  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: doc/sync_frame_tx.md
Name: sync_frame_tx

Overview:
- Serial frame transmitter: takes a parallel word over a valid/ready handshake and emits it bit-serially, one bit per clock.
- Each frame is the sync pattern 1011, then the payload MSB first, then an idle-low gap.
- Produces the stream that the team's 1011 sequence detector consumes on the receive side.
- Sits between a parallel data source and the single-wire serial link.

Parameters:
- DATA_W, 8: payload width in bits; legal range 1..32.
- SYNC_W, 4: sync pattern width.
- SYNC_PAT, 4'b1011: sync pattern, sent MSB first.
- GAP_BITS, 2: low idle bits after each frame; 0 is legal.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- din  input  DATA_W  payload word; sampled only on accept.
- din_valid  input  1  source has a word.
- din_ready  output  1  block can accept; equals (state==IDLE) && !reset.
- out  output  1  registered serial data; low whenever no frame bit is being sent.
- out_valid  output  1  registered; high exactly while a frame bit (sync, payload or parity) is on out.
- frame_done  output  1  registered one-cycle pulse, high during the final frame bit.

Behaviour:
- Reset: synchronous, active-high, evaluated on the clk rising edge.
  - Clears state to IDLE; out=0, out_valid=0, frame_done=0, shift register=0.
  - din_ready is 0 while reset is high.
- Accept: occurs in cycle N when din_valid && din_ready at a rising edge.
  - din is captured into the shift register at that edge.
  - Later changes on din are ignored until the next accept.
- States: IDLE, SYNC, DATA, [PARITY], GAP.
  - IDLE: out=0, out_valid=0. On accept go to SYNC; otherwise stay.
  - SYNC: sends SYNC_PAT[SYNC_W-1] down to SYNC_PAT[0], one bit per cycle, then goes to DATA.
  - DATA: sends din[DATA_W-1] down to din[0]. The next state is PARITY if it is compiled in; otherwise GAP, or IDLE if GAP_BITS==0.
  - GAP: out=0, out_valid=0 for GAP_BITS cycles, then IDLE.
- Latency: frame bit k is on out in cycle N+1+k.
- Frame length: L = SYNC_W+DATA_W bits, plus 1 with parity.
- frame_done is high in cycle N+L.
- Throughput: with din_valid held high, the minimum accept-to-accept period is L+GAP_BITS+1 cycles. There is no accept during the last frame bit or during the gap.
- din_valid while busy: not accepted and no effect. The source must hold din and din_valid until accepted.
- Reset mid-frame: the frame is aborted at that edge.
  - out and out_valid are 0 the next cycle.
  - No frame_done pulse.
  - Any partially captured data is discarded.
- Counters: bit counter width is clog2(max(SYNC_W, DATA_W, GAP_BITS)+1). It loads per state and must not wrap.
- No bit stuffing: payload may contain 1011; framing ambiguity is handled by the receiver.

Optional Feature:
- Macro: SYNC_FRAME_TX_PARITY_EN.
- Defined: a PARITY state follows DATA and sends one bit equal to the even-parity XOR-reduction of the captured payload. That bit has out_valid=1, and frame_done moves to it.
- Undefined: the PARITY state and its logic are absent; DATA goes straight to GAP or IDLE.

Test Plan:
- Single frame, macro off, defaults, din=8'hA5 accepted in cycle N:
  - out in cycles N+1..N+12 = 1,0,1,1,1,0,1,0,0,1,0,1 with out_valid=1.
  - frame_done=1 only in N+12.
  - out=0 and out_valid=0 in N+13..N+14.
  - din_ready=1 in N+15.
- Back-to-back, macro off: din_valid held with 8'hFF then 8'h00.
  - Accepts occur in N and N+15.
  - Second frame is 1,0,1,1,0,0,0,0,0,0,0,0 in cycles N+16..N+27.
  - din_ready=0 in cycles N+1..N+14.
- Parity, macro on: din=8'hA5 gives 13th bit 0 in N+13, with frame_done in N+13. din=8'h07 gives 13th bit 1.
- Data stability: din changes from 8'hA5 to 8'h3C in cycle N+2 → transmitted payload remains A5.
- Reset mid-frame: reset asserted in cycle N+6 → out=0, out_valid=0, frame_done=0 from N+7 on. After reset drops, din_ready=1 and a new 8'h5A frame is sent correctly.
- GAP_BITS=0, macro off: din_valid held → accepts occur every 13 cycles and out_valid is low only in the accept cycle between frames.
